// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//
// Multi-cycle issue sequencer sitting in front of a combinational RV32I ALU.
// It accepts one decoded instruction at a time. It drives the ALU operands and
// control for one or two cycles, samples the ALU outputs, and presents a
// registered response.
//
// Ports:
//   clk, reset              single rising-edge clock, synchronous active-high reset
//   req_valid / req_ready   request handshake (ready only in IDLE and out of reset)
//   req_kind                00 R-type, 01 I-type ALU, 10 load/store address, 11 branch
//   req_funct3, req_funct7b5  instruction funct3 and bit 30
//   req_rs1/rs2/imm/pc      operands (imm already sign-extended)
//   alu_a, alu_b, alu_ctrl  ALU operand/control drive (idle: 0, 0, ADD)
//   alu_result, alu_zero    combinational ALU outputs sampled back
//   rsp_valid / rsp_ready   response handshake
//   rsp_result              ALU result, or branch target for branches
//   rsp_taken               branch outcome (0 for non-branch)
//   rsp_illegal             unsupported encoding
// -----------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_kind,
    input  logic [2:0]      req_funct3,
    input  logic            req_funct7b5,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    input  logic [XLEN-1:0] req_imm,
    input  logic [XLEN-1:0] req_pc,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_result,
    output logic            rsp_taken,
    output logic            rsp_illegal
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXEC   = 2'd1,
        BR_TGT = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;

    localparam logic [1:0] KIND_R  = 2'b00;
    localparam logic [1:0] KIND_I  = 2'b01;
    localparam logic [1:0] KIND_LS = 2'b10;
    localparam logic [1:0] KIND_BR = 2'b11;

    state_t          state_q;
    logic [XLEN-1:0] rs1_q, rs2_q, imm_q, pc_q;
    logic [3:0]      ctrl_q;
    logic            use_imm_q;
    logic            is_branch_q;
    logic            bne_q;       // funct3[0]: inverts the zero flag for BNE
    logic            taken_q;     // branch outcome held across BR_TGT
    logic            rsp_valid_q, rsp_taken_q, rsp_illegal_q;
    logic [XLEN-1:0] rsp_result_q;

    logic            dec_legal;
    logic [3:0]      dec_ctrl;
    logic            dec_use_imm;

    // Decode of the request as presented; only consumed on an accept edge.
    always_comb begin
        dec_legal   = 1'b1;
        dec_ctrl    = CTRL_ADD;
        dec_use_imm = 1'b0;
        case (req_kind)
            KIND_R: begin
                case (req_funct3)
                    3'b000:  dec_ctrl = req_funct7b5 ? CTRL_SUB : CTRL_ADD;
                    3'b110:  dec_ctrl = CTRL_OR;
                    3'b111:  dec_ctrl = CTRL_AND;
                    default: dec_legal = 1'b0;
                endcase
            end
            KIND_I: begin
                dec_use_imm = 1'b1;
                case (req_funct3)
                    3'b000:  dec_ctrl = CTRL_ADD;
                    3'b110:  dec_ctrl = CTRL_OR;
                    3'b111:  dec_ctrl = CTRL_AND;
                    default: dec_legal = 1'b0;
                endcase
            end
            KIND_LS: begin
                dec_use_imm = 1'b1;
                dec_ctrl    = CTRL_ADD;
            end
            default: begin
                // Branch compare is a SUB of rs1 and rs2; only BEQ/BNE supported.
                dec_ctrl  = CTRL_SUB;
                dec_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001);
            end
        endcase
    end

    assign req_ready = (state_q == IDLE) & ~reset;

    // ALU drive follows the state: compare/op in EXEC, target add in BR_TGT.
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = CTRL_ADD;
        case (state_q)
            EXEC: begin
                alu_a    = rs1_q;
                alu_b    = use_imm_q ? imm_q : rs2_q;
                alu_ctrl = ctrl_q;
            end
            BR_TGT: begin
                alu_a    = pc_q;
                alu_b    = imm_q;
                alu_ctrl = CTRL_ADD;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            rs1_q         <= '0;
            rs2_q         <= '0;
            imm_q         <= '0;
            pc_q          <= '0;
            ctrl_q        <= CTRL_ADD;
            use_imm_q     <= 1'b0;
            is_branch_q   <= 1'b0;
            bne_q         <= 1'b0;
            taken_q       <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= '0;
            rsp_taken_q   <= 1'b0;
            rsp_illegal_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        rs1_q       <= req_rs1;
                        rs2_q       <= req_rs2;
                        imm_q       <= req_imm;
                        pc_q        <= req_pc;
                        ctrl_q      <= dec_ctrl;
                        use_imm_q   <= dec_use_imm;
                        is_branch_q <= (req_kind == KIND_BR);
                        bne_q       <= req_funct3[0];
                        if (dec_legal) begin
                            state_q <= EXEC;
                        end else begin
                            // Illegal encodings skip the ALU entirely.
                            rsp_valid_q   <= 1'b1;
                            rsp_result_q  <= '0;
                            rsp_taken_q   <= 1'b0;
                            rsp_illegal_q <= 1'b1;
                            state_q       <= RESP;
                        end
                    end
                end
                EXEC: begin
                    if (is_branch_q) begin
                        taken_q <= alu_zero ^ bne_q;
                        state_q <= BR_TGT;
                    end else begin
                        rsp_valid_q   <= 1'b1;
                        rsp_result_q  <= alu_result;
                        rsp_taken_q   <= 1'b0;
                        rsp_illegal_q <= 1'b0;
                        state_q       <= RESP;
                    end
                end
                BR_TGT: begin
                    // Outcome is published together with the target so rsp_*
                    // only change on entry to RESP.
                    rsp_valid_q   <= 1'b1;
                    rsp_result_q  <= alu_result;
                    rsp_taken_q   <= taken_q;
                    rsp_illegal_q <= 1'b0;
                    state_q       <= RESP;
                end
                default: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
            endcase
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_taken   = rsp_taken_q;
    assign rsp_illegal = rsp_illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_kind;
    logic [2:0]  req_funct3;
    logic        req_funct7b5;
    logic [31:0] req_rs1, req_rs2, req_imm, req_pc;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_taken;
    logic        rsp_illegal;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.XLEN(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_kind     (req_kind),
        .req_funct3   (req_funct3),
        .req_funct7b5 (req_funct7b5),
        .req_rs1      (req_rs1),
        .req_rs2      (req_rs2),
        .req_imm      (req_imm),
        .req_pc       (req_pc),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_ctrl     (alu_ctrl),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_taken    (rsp_taken),
        .rsp_illegal  (rsp_illegal)
    );

    // Combinational ALU the sequencer talks to.
    always_comb begin
        case (alu_ctrl)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0010: alu_result = alu_a + alu_b;
            4'b0110: alu_result = alu_a - alu_b;
            default: alu_result = 32'hDEAD_BEEF;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour of one instruction, straight from the ISA meaning.
    task automatic ref_model(input logic [1:0] kind, input logic [2:0] f3, input logic b5,
                             input logic [31:0] rs1, rs2, imm, pc,
                             output logic ill, output logic [31:0] res, output logic tk,
                             output int lat, output logic [3:0] ctl, output logic [31:0] a, b);
        ill = 1'b0; res = 32'd0; tk = 1'b0; lat = 2; ctl = 4'b0010; a = rs1; b = rs2;
        if (kind == 2'b11) begin
            lat = 3; ctl = 4'b0110;
            if (f3 == 3'd0)      tk = (rs1 == rs2);
            else if (f3 == 3'd1) tk = (rs1 != rs2);
            else                 ill = 1'b1;
            res = pc + imm;
        end else if (kind == 2'b10) begin
            b = imm; res = rs1 + imm;
        end else begin
            if (kind == 2'b01) b = imm;
            if (f3 == 3'd0) begin
                if (kind == 2'b00 && b5) begin ctl = 4'b0110; res = rs1 - rs2; end
                else res = rs1 + b;
            end else if (f3 == 3'd6) begin ctl = 4'b0001; res = rs1 | b; end
            else if (f3 == 3'd7) begin ctl = 4'b0000; res = rs1 & b; end
            else ill = 1'b1;
        end
        if (ill) begin res = 32'd0; tk = 1'b0; lat = 1; end
    endtask

    task automatic wait_ready();
        int w = 0;
        while (req_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    endtask

    // Runs one instruction; hold = extra RESP cycles with rsp_ready low.
    task automatic run_txn(input logic [1:0] kind, input logic [2:0] f3, input logic b5,
                           input logic [31:0] rs1, rs2, imm, pc, input int hold);
        logic ill, tk;
        logic [31:0] res, ea, eb;
        logic [3:0] ctl;
        int lat;
        ref_model(kind, f3, b5, rs1, rs2, imm, pc, ill, res, tk, lat, ctl, ea, eb);
        wait_ready();
        req_valid = 1'b1; req_kind = kind; req_funct3 = f3; req_funct7b5 = b5;
        req_rs1 = rs1; req_rs2 = rs2; req_imm = imm; req_pc = pc;
        rsp_ready = (hold == 0);
        @(negedge clk);
        req_valid = 1'b0;
        req_rs1 = $urandom; req_rs2 = $urandom; req_imm = $urandom; req_pc = $urandom;
        for (int k = 1; k <= lat; k++) begin
            if (k > 1) @(negedge clk);
            chk("rsp_valid_latency", {31'd0, rsp_valid}, {31'd0, k == lat});
            chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
            if (k == 1 && !ill) begin
                chk("exec_alu_a", alu_a, ea);
                chk("exec_alu_b", alu_b, eb);
                chk("exec_alu_ctrl", {28'd0, alu_ctrl}, {28'd0, ctl});
            end
            if (k == 2 && lat == 3) begin
                chk("brtgt_alu_a", alu_a, pc);
                chk("brtgt_alu_b", alu_b, imm);
                chk("brtgt_alu_ctrl", {28'd0, alu_ctrl}, 32'd2);
            end
        end
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) @(negedge clk);
            chk("rsp_valid_hold", {31'd0, rsp_valid}, 32'd1);
            chk("rsp_result", rsp_result, res);
            chk("rsp_taken", {31'd0, rsp_taken}, {31'd0, tk});
            chk("rsp_illegal", {31'd0, rsp_illegal}, {31'd0, ill});
            chk("resp_alu_idle", {alu_a[13:0], alu_b[13:0], alu_ctrl}, 32'd2);
            if (h > 0) chk("req_ready_bp", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
        chk("req_ready_back", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [1:0]  k;
        logic [2:0]  f;
        logic [31:0] r1, r2;
        reset = 1'b1; req_valid = 1'b0; req_kind = 2'd0; req_funct3 = 3'd0;
        req_funct7b5 = 1'b0; req_rs1 = '0; req_rs2 = '0; req_imm = '0; req_pc = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_req_ready", {31'd0, req_ready}, 32'd0);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_result", rsp_result, 32'd0);
        chk("reset_rsp_flags", {30'd0, rsp_taken, rsp_illegal}, 32'd0);
        chk("reset_alu_idle", alu_a | alu_b, 32'd0);
        chk("reset_alu_ctrl", {28'd0, alu_ctrl}, 32'd2);
        // Request presented during reset must not be taken.
        req_valid = 1'b1; req_kind = 2'b00; req_funct3 = 3'b010;
        @(negedge clk);
        chk("reset_no_accept", {31'd0, rsp_valid}, 32'd0);
        req_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        // Directed scenarios
        run_txn(2'b00, 3'b000, 1'b1, 32'h10, 32'h3, 32'h0, 32'h0, 0);
        run_txn(2'b11, 3'b000, 1'b0, 32'h55, 32'h55, 32'hFFFF_FFF0, 32'h100, 0);
        run_txn(2'b11, 3'b001, 1'b0, 32'd7, 32'd7, 32'h40, 32'h200, 0);
        run_txn(2'b11, 3'b001, 1'b0, 32'd7, 32'd8, 32'h40, 32'h200, 0);
        run_txn(2'b00, 3'b010, 1'b0, 32'h1, 32'h2, 32'h0, 32'h0, 0);
        run_txn(2'b11, 3'b100, 1'b0, 32'h1, 32'h1, 32'h8, 32'h8, 1);
        run_txn(2'b01, 3'b000, 1'b1, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h0, 5);

        // A request waiting while RESP drains must not be accepted on that edge.
        req_valid = 1'b1; req_kind = 2'b10; req_funct3 = 3'b000; req_funct7b5 = 1'b0;
        req_rs1 = 32'h1000; req_rs2 = 32'h0; req_imm = 32'h24; req_pc = 32'h0;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("accept_edge", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("ls_resp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("ls_resp_result", rsp_result, 32'h1024);
        req_valid = 1'b1; req_kind = 2'b00; req_funct3 = 3'b111;
        req_rs1 = 32'hF0F0; req_rs2 = 32'h0FF0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("no_accept_on_resp_exit", {31'd0, req_ready}, 32'd1);
        chk("no_accept_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("second_accepted", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("second_result", rsp_result, 32'h00F0);
        @(negedge clk);

        // Reset during BR_TGT aborts the branch.
        wait_ready();
        req_valid = 1'b1; req_kind = 2'b11; req_funct3 = 3'b000;
        req_rs1 = 32'h9; req_rs2 = 32'h9; req_imm = 32'h10; req_pc = 32'h300;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("mid_brtgt_ctrl", {28'd0, alu_ctrl}, 32'd2);
        chk("mid_brtgt_a", alu_a, 32'h300);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("abort_req_ready", {31'd0, req_ready}, 32'd0);
        chk("abort_rsp_result", rsp_result, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_rsp_valid2", {31'd0, rsp_valid}, 32'd0);
        chk("ready_after_reset", {31'd0, req_ready}, 32'd1);
        run_txn(2'b00, 3'b110, 1'b0, 32'hF0, 32'h0F, 32'h0, 32'h0, 0);

        // Randomized instructions
        for (int i = 0; i < 200; i++) begin
            k = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) f = 3'($urandom_range(0, 7));
            else if (k == 2'b11) f = 3'($urandom_range(0, 1));
            else begin
                case ($urandom_range(0, 2))
                    0: f = 3'd0;
                    1: f = 3'd6;
                    default: f = 3'd7;
                endcase
            end
            r1 = $urandom;
            r2 = ($urandom_range(0, 2) == 0) ? r1 : $urandom;
            run_txn(k, f, 1'($urandom_range(0, 1)), r1, r2, $urandom, $urandom,
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
